// File: rtl/cpu_bus_wait_bridge_if.sv
// Bus bundle between the RV32 CPU wrapper, the wait bridge and the slow target.
// The bridge takes the slave view. The environment (CPU wrapper plus target,
// or a testbench) takes the master view.
//
// Handshake: the CPU side issues a one-cycle cpu_req_i strobe with its address,
// data and strobes valid in that same cycle. The target side sees per_req_o held
// high with stable per_* fields until it returns a one-cycle per_ack_i. For
// reads, per_rdata_i must be valid in the cycle where per_ack_i is high.
interface cpu_bus_wait_bridge_if #(
  parameter int address_width = 32
);
  logic                     cpu_req_i;
  logic [address_width-1:0] cpu_address_i;
  logic [31:0]              cpu_wdata_i;
  logic [3:0]               cpu_wstrb_i;
  logic [31:0]              cpu_rdata_o;
  logic                     cpu_halt_o;
  logic                     per_req_o;
  logic [address_width-1:0] per_addr_o;
  logic [31:0]              per_wdata_o;
  logic [3:0]               per_wstrb_o;
  logic                     per_we_o;
  logic [31:0]              per_rdata_i;
  logic                     per_ack_i;
  logic                     err_o;
  logic                     err_clr_i;

  modport slave (
    input  cpu_req_i, cpu_address_i, cpu_wdata_i, cpu_wstrb_i,
    input  per_rdata_i, per_ack_i, err_clr_i,
    output cpu_rdata_o, cpu_halt_o, per_req_o, per_addr_o,
    output per_wdata_o, per_wstrb_o, per_we_o, err_o
  );

  modport master (
    output cpu_req_i, cpu_address_i, cpu_wdata_i, cpu_wstrb_i,
    output per_rdata_i, per_ack_i, err_clr_i,
    input  cpu_rdata_o, cpu_halt_o, per_req_o, per_addr_o,
    input  per_wdata_o, per_wstrb_o, per_we_o, err_o
  );
endinterface

// File: rtl/cpu_bus_wait_bridge.sv
// cpu_bus_wait_bridge: turns the CPU wrapper's one-cycle access strobe into a
// held request/acknowledge handshake toward slow targets. While an access is
// outstanding, the CPU is kept halted. Read data goes back through a register.
//
// Optional macro BUS_TIMEOUT_EN: when it is defined, an access that receives
// no ack within TimeoutCycles BUSY cycles is aborted. The abort returns
// ErrorData and sets the sticky err flag. When it is undefined, the bridge
// waits indefinitely and err is tied low.
//
// dbg_state exposes the FSM encoding: 0 = IDLE, 1 = BUSY, 2 = DONE.
module cpu_bus_wait_bridge #(
  parameter int          address_width = 32,
  parameter int          TimeoutCycles = 64,
  parameter logic [31:0] ErrorData     = 32'hDEADBEEF
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  cpu_bus_wait_bridge_if.slave        bus,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state;
  logic                     per_req;
  logic                     halt;
  logic [31:0]              rdata;
  logic [address_width-1:0] addr;
  logic [31:0]              wdata;
  logic [3:0]               wstrb;

`ifdef BUS_TIMEOUT_EN
  localparam logic [15:0] timeout_limit = 16'(TimeoutCycles);
  logic [15:0] count;
  logic [15:0] count_next;
  logic        err;

  // count holds the number of BUSY cycles already finished without an ack.
  // count_next includes the BUSY cycle that ends on this edge.
  assign count_next = count + 16'd1;
`else
  // In this build the timeout parameters and err_clr_i have no function.
  localparam logic [31:0] unused_timeout_params = ErrorData ^ 32'(TimeoutCycles);
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr_i;
`endif

  // Request FSM. It latches the access, holds the handshake, and returns read data.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      per_req <= 1'b0;
      halt    <= 1'b0;
      rdata   <= 32'd0;
      addr    <= '0;
      wdata   <= 32'd0;
      wstrb   <= 4'd0;
`ifdef BUS_TIMEOUT_EN
      count   <= 16'd0;
      err     <= 1'b0;
`endif
    end else begin
`ifdef BUS_TIMEOUT_EN
      // A timeout set later in this block overrides this clear on the same edge.
      if (bus.err_clr_i) err <= 1'b0;
`endif
      case (state)
        IDLE, DONE: begin
          // In DONE a new strobe is accepted as it is in IDLE, which allows
          // back-to-back accesses.
          if (bus.cpu_req_i) begin
            addr    <= bus.cpu_address_i;
            wdata   <= bus.cpu_wdata_i;
            wstrb   <= bus.cpu_wstrb_i;
            per_req <= 1'b1;
            halt    <= 1'b1;
`ifdef BUS_TIMEOUT_EN
            count   <= 16'd0;
`endif
            state   <= BUSY;
          end else begin
            state   <= IDLE;
          end
        end
        BUSY: begin
          // When the ack and the timeout limit fall on the same edge, the ack
          // wins. A new CPU strobe is ignored in this state.
          if (bus.per_ack_i) begin
            if (wstrb == 4'd0) rdata <= bus.per_rdata_i;
            per_req <= 1'b0;
            halt    <= 1'b0;
            state   <= DONE;
`ifdef BUS_TIMEOUT_EN
          end else if (count_next >= timeout_limit) begin
            count   <= timeout_limit;
            rdata   <= ErrorData;
            err     <= 1'b1;
            per_req <= 1'b0;
            halt    <= 1'b0;
            state   <= DONE;
          end else begin
            count   <= count_next;
`endif
          end
        end
        default: begin
          per_req <= 1'b0;
          halt    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_rdata_o = rdata;
  assign bus.cpu_halt_o  = halt;
  assign bus.per_req_o   = per_req;
  assign bus.per_addr_o  = addr;
  assign bus.per_wdata_o = wdata;
  assign bus.per_wstrb_o = wstrb;
  assign bus.per_we_o    = |wstrb;
`ifdef BUS_TIMEOUT_EN
  assign bus.err_o       = err;
`else
  assign bus.err_o       = 1'b0;
`endif
  assign dbg_state       = state;

endmodule

// File: tb/tb_cpu_bus_wait_bridge.sv
// Testbench for cpu_bus_wait_bridge. It runs table vectors from the test plan,
// then hand-written reset, timeout and spurious-event sequences, then
// randomized accesses checked against a transaction-level model.
module tb_cpu_bus_wait_bridge;
  localparam int          TO       = 8;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;
`ifdef BUS_TIMEOUT_EN
  localparam bit to_en = 1'b1;
`else
  localparam bit to_en = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  cpu_bus_wait_bridge_if #(.address_width(32)) bus ();

  cpu_bus_wait_bridge #(
    .address_width(32),
    .TimeoutCycles(TO),
    .ErrorData    (ERR_DATA)
  ) dut (
    .clk_i    (clk),
    .reset_i  (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata;
  logic        model_err;
  logic [31:0] last_addr;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ack_at;     // BUSY cycle index (0-based) carrying the ack
    logic [31:0] rd;
    bit          b2b;        // issue in the DONE cycle of the previous access
    int          exp_busy;   // expected number of BUSY cycles (halt high)
    logic [31:0] exp_rdata;  // expected cpu_rdata_o in the DONE cycle
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.cpu_req_i     = 1'b0;
    bus.cpu_address_i = 32'd0;
    bus.cpu_wdata_i   = 32'd0;
    bus.cpu_wstrb_i   = 4'd0;
    bus.per_rdata_i   = 32'd0;
    bus.per_ack_i     = 1'b0;
    bus.err_clr_i     = 1'b0;
  endtask

  // Called at a negedge. It spends one cycle not requesting and pulses a
  // spurious ack, which must be ignored.
  task automatic idle_gap();
    bus.per_ack_i   = 1'b1;
    bus.per_rdata_i = $urandom;
    @(negedge clk);
    bus.per_ack_i   = 1'b0;
    check("idle_state", 32'(dbg_state), 32'd0);
    check("idle_req", 32'(bus.per_req_o), 32'd0);
    check("idle_halt", 32'(bus.cpu_halt_o), 32'd0);
    check("idle_rdata", bus.cpu_rdata_o, model_rdata);
    check("idle_addr", bus.per_addr_o, last_addr);
  endtask

  // Called at a negedge in IDLE or DONE. It returns at the negedge of the DONE cycle.
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int ack_at,
                        input logic [31:0] rd, input bit noise, input bit clr_hold,
                        output int busy_cycles);
    int n;
    bit finished;
    bit acked;
    bus.cpu_req_i     = 1'b1;
    bus.cpu_address_i = addr;
    bus.cpu_wdata_i   = wdata;
    bus.cpu_wstrb_i   = wstrb;
    @(negedge clk);
    bus.cpu_req_i     = 1'b0;
    bus.cpu_address_i = $urandom;
    bus.cpu_wdata_i   = $urandom;
    bus.cpu_wstrb_i   = 4'($urandom);
    n = 0; finished = 0; acked = 0;
    if (clr_hold) model_err = 1'b0;
    while (!finished && n < 200) begin
      check("busy_state", 32'(dbg_state), 32'd1);
      check("busy_req", 32'(bus.per_req_o), 32'd1);
      check("busy_halt", 32'(bus.cpu_halt_o), 32'd1);
      check("busy_addr", bus.per_addr_o, addr);
      check("busy_wdata", bus.per_wdata_o, wdata);
      check("busy_wstrb", 32'(bus.per_wstrb_o), 32'(wstrb));
      check("busy_we", 32'(bus.per_we_o), 32'(wstrb != 4'd0));
      if (n == ack_at) begin
        bus.per_ack_i   = 1'b1;
        bus.per_rdata_i = rd;
      end else if (noise && $urandom_range(0, 2) == 0) begin
        bus.cpu_req_i = 1'b1;
      end
      bus.err_clr_i = clr_hold;
      @(negedge clk);
      acked = (n == ack_at);
      bus.per_ack_i   = 1'b0;
      bus.cpu_req_i   = 1'b0;
      bus.per_rdata_i = $urandom;
      bus.err_clr_i   = 1'b0;
      n++;
      finished = acked || (to_en && n == TO);
    end
    busy_cycles = n;
    last_addr   = addr;
    if (!finished) begin
      check("busy_bound", 32'd0, 32'd1);
    end else begin
      if (acked) begin
        if (wstrb == 4'd0) model_rdata = rd;
      end else begin
        model_rdata = ERR_DATA;
        model_err   = 1'b1;
      end
      exp_q.push_back(model_rdata);
      check("done_state", 32'(dbg_state), 32'd2);
      check("done_req", 32'(bus.per_req_o), 32'd0);
      check("done_halt", 32'(bus.cpu_halt_o), 32'd0);
      check("done_rdata", bus.cpu_rdata_o, exp_q.pop_front());
      check("done_err", 32'(bus.err_o), 32'(model_err));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t vt[6];
    int busy;
    // Bound the whole run so that the bench always terminates.
    fork
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    vt[0] = '{32'h0000_1000, 32'h0,         4'b0000, 0, 32'h1234_5678, 1'b0, 1, 32'h1234_5678};
    vt[1] = '{32'h0000_2004, 32'hA5A5_0001, 4'b0011, 5, 32'h5555_5555, 1'b0, 6, 32'h1234_5678};
    vt[2] = '{32'h0000_3000, 32'h0,         4'b0000, 2, 32'hCAFE_0001, 1'b0, 3, 32'hCAFE_0001};
    vt[3] = '{32'h0000_3004, 32'h0,         4'b0000, 1, 32'hCAFE_0002, 1'b1, 2, 32'hCAFE_0002};
    vt[4] = '{32'h0000_4000, 32'h0F0F_0F0F, 4'b1111, 0, 32'h7777_7777, 1'b1, 1, 32'hCAFE_0002};
    vt[5] = '{32'h0000_5000, 32'h0,         4'b0000, TO-1, 32'h0BAD_F00D, 1'b0, TO, 32'h0BAD_F00D};

    idle_inputs();
    rst = 1'b1;
    model_rdata = 32'd0; model_err = 1'b0; last_addr = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_req", 32'(bus.per_req_o), 32'd0);
    check("rst_halt", 32'(bus.cpu_halt_o), 32'd0);
    check("rst_rdata", bus.cpu_rdata_o, 32'd0);
    check("rst_addr", bus.per_addr_o, 32'd0);
    check("rst_wdata", bus.per_wdata_o, 32'd0);
    check("rst_wstrb", 32'(bus.per_wstrb_o), 32'd0);
    check("rst_we", 32'(bus.per_we_o), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors.
    for (int i = 0; i < 6; i++) begin
      if (!vt[i].b2b) begin
        @(negedge clk);
        idle_gap();
      end
      access(vt[i].addr, vt[i].wdata, vt[i].wstrb, vt[i].ack_at, vt[i].rd, 1'b1, 1'b0, busy);
      check("tbl_busy", 32'(busy), 32'(vt[i].exp_busy));
      check("tbl_rdata", bus.cpu_rdata_o, vt[i].exp_rdata);
    end

    // Reset asserted during the 3rd BUSY cycle.
    @(negedge clk);
    bus.cpu_req_i = 1'b1; bus.cpu_address_i = 32'h0000_6000; bus.cpu_wstrb_i = 4'd0;
    @(negedge clk);
    bus.cpu_req_i = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_state", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_state", 32'(dbg_state), 32'd0);
    check("midrst_req", 32'(bus.per_req_o), 32'd0);
    check("midrst_halt", 32'(bus.cpu_halt_o), 32'd0);
    check("midrst_rdata", bus.cpu_rdata_o, 32'd0);
    check("midrst_addr", bus.per_addr_o, 32'd0);
    model_rdata = 32'd0; model_err = 1'b0; last_addr = 32'd0;
    idle_gap();
    access(32'h0000_6004, 32'h0, 4'd0, 3, 32'h600D_CAFE, 1'b0, 1'b0, busy);
    check("postrst_busy", 32'(busy), 32'd4);

`ifdef BUS_TIMEOUT_EN
    // A read with no ack aborts after TO BUSY cycles.
    @(negedge clk); idle_gap();
    access(32'h0000_7000, 32'h0, 4'd0, 1000, 32'h0, 1'b0, 1'b0, busy);
    check("to_busy", 32'(busy), 32'(TO));
    check("to_rdata", bus.cpu_rdata_o, ERR_DATA);
    repeat (3) begin
      @(negedge clk);
      check("to_err_sticky", 32'(bus.err_o), 32'd1);
    end
    bus.err_clr_i = 1'b1;
    @(negedge clk);
    bus.err_clr_i = 1'b0; model_err = 1'b0;
    check("to_err_clr", 32'(bus.err_o), 32'd0);
    // A write timeout with err_clr held: the set wins. ErrorData is returned for writes too.
    access(32'h0000_7004, 32'h1111_2222, 4'b1000, 1000, 32'h0, 1'b0, 1'b1, busy);
    check("to_wr_rdata", bus.cpu_rdata_o, ERR_DATA);
    check("to_wr_err", 32'(bus.err_o), 32'd1);
    bus.err_clr_i = 1'b1;
    @(negedge clk);
    bus.err_clr_i = 1'b0; model_err = 1'b0;
    // An ack on the last allowed cycle completes normally.
    access(32'h0000_7008, 32'h0, 4'd0, TO-1, 32'h0000_ACED, 1'b0, 1'b0, busy);
    check("to_edge_busy", 32'(busy), 32'(TO));
    check("to_edge_err", 32'(bus.err_o), 32'd0);
    check("to_edge_rdata", bus.cpu_rdata_o, 32'h0000_ACED);
`else
    // Without the timeout feature, a long wait never aborts.
    @(negedge clk); idle_gap();
    access(32'h0000_7000, 32'h0, 4'd0, 70, 32'h0000_1070, 1'b0, 1'b1, busy);
    check("long_busy", 32'(busy), 32'd71);
    check("long_err", 32'(bus.err_o), 32'd0);
`endif

    // Randomized accesses checked against the model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, d, r;
      logic [3:0]  s;
      int          k, exp_busy;
      bit          clr;
      a = $urandom; d = $urandom; r = $urandom;
      s = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      k = to_en ? $urandom_range(0, TO + 1) : $urandom_range(0, 10);
      clr = ($urandom_range(0, 3) == 0);
      if (clr) model_err = 1'b0;
      exp_busy = (to_en && k >= TO) ? TO : k + 1;
      if ($urandom_range(0, 1) == 0) begin
        @(negedge clk);
        idle_gap();
      end
      access(a, d, s, k, r, 1'b1, clr, busy);
      check("rnd_busy", 32'(busy), 32'(exp_busy));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
